// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes and datapath select codes.
package riscv_ctrl_pkg;

    // Encodings are visible on the LCD, so they are fixed explicitly.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALUOp plus the instruction function fields onto
// the ALU operation code. Purely combinational.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    // Subtract only for R-type with funct7[5] set; I-type addi never subtracts.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RISC-V datapath, with an enable for
// free-run / single-step and LCD debug outputs (state, illegal, instret).
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [NBITS-1:0] instret
);

    state_t           state_q, state_d, stateNext;
    logic             illegal_q, illegal_d;
    logic [NBITS-1:0] instret_q, instret_d;

    logic       pcUpdate, branch, irWriteS, memWriteS, regWriteS;
    logic [1:0] aluOp;

    always_comb begin
        stateNext = state_q;
        case (state_q)
            FETCH: stateNext = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_RTYPE:     stateNext = EXECUTER;
                    OP_IALU:      stateNext = EXECUTEI;
                    OP_BEQ:       stateNext = BEQ;
                    OP_JAL:       stateNext = JAL;
                    default:      stateNext = HALT;
                endcase
            end
            MEMADR:                     stateNext = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:                    stateNext = MEMWB;
            MEMWB, MEMWRITE, ALUWB, BEQ: stateNext = FETCH;
            EXECUTER, EXECUTEI, JAL:    stateNext = ALUWB;
            default:                    stateNext = HALT;
        endcase
    end

    // Every state change, the sticky flag and the retire count are en-qualified.
    always_comb begin
        state_d   = en ? stateNext : state_q;
        illegal_d = illegal_q | (en && state_q == DECODE && stateNext == HALT);
        instret_d = instret_q;
        if (en && stateNext == FETCH) begin
            instret_d = instret_q + NBITS'(1);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        irWriteS  = 1'b0;
        pcUpdate  = 1'b0;
        memWriteS = 1'b0;
        regWriteS = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        aluOp     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irWriteS  = 1'b1;
                pcUpdate  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
            MEMADR:   begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = RES_DATA; regWriteS = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; memWriteS = 1'b1; end
            EXECUTER: begin ALUSrcA = SRCA_RS1; aluOp = ALUOP_FUNCT; end
            EXECUTEI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; aluOp = ALUOP_FUNCT; end
            ALUWB:    regWriteS = 1'b1;
            BEQ:      begin ALUSrcA = SRCA_RS1; aluOp = ALUOP_SUB; branch = 1'b1; end
            JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pcUpdate = 1'b1; end
            default:  ;
        endcase
    end

    // Strobes are gated by en so a frozen core never writes anything.
    assign PCWrite  = en & (pcUpdate | (branch & zero));
    assign IRWrite  = en & irWriteS;
    assign MemWrite = en & memWriteS;
    assign RegWrite = en & regWriteS;

    alu_decoder u_aluDecoder (
        .ALUOp      (aluOp),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
